// File: rtl/byte_pack_fifo_pkg.sv
// byte_pack_fifo_pkg: shared byte/lane constants and MSB-first lane helpers for the byte packer.
package byte_pack_fifo_pkg;
    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int ERR_DROP   = 0;
    localparam int ERR_BYTES  = 1;

    function automatic logic [BYTE_W-1:0] lane_get(input logic [31:0] w, input int k);
        return w[31 - BYTE_W*k -: BYTE_W];
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w, input int k, input logic [BYTE_W-1:0] b);
        logic [31:0] r;
        r = w;
        r[31 - BYTE_W*k -: BYTE_W] = b;
        return r;
    endfunction
endpackage

// File: rtl/byte_pack_fifo_if.sv
// byte_pack_fifo_if: write/read handshake and status bundle of the byte packer.
interface byte_pack_fifo_if #(parameter int DEPTH = 16);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [2:0]       wr_bytes;
    logic             wr_ready;
    logic             rd_en;
    logic             flush;
    logic [31:0]      dout;
    logic             dout_valid;
    logic [2:0]       dout_bytes;
    logic [CNT_W-1:0] count;
    logic [1:0]       err;

    modport master (output wr_en, wr_data, wr_bytes, rd_en, flush,
                    input  wr_ready, dout, dout_valid, dout_bytes, count, err);
    modport slave  (input  wr_en, wr_data, wr_bytes, rd_en, flush,
                    output wr_ready, dout, dout_valid, dout_bytes, count, err);
endinterface

// File: rtl/byte_pack_fifo_merge.sv
// byte_pack_merge: shifts the buffer down by pop_n, appends wr_n new bytes, keeps the tail zero.
module byte_pack_merge
    import byte_pack_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][BYTE_W-1:0] buf_i,
    input  logic [CNT_W-1:0]             count_i,
    input  logic [2:0]                   pop_n_i,
    input  logic [31:0]                  wr_data_i,
    input  logic [2:0]                   wr_n_i,
    output logic [DEPTH-1:0][BYTE_W-1:0] buf_o,
    output logic [CNT_W-1:0]             count_o
);
    int base;

    // Entries past count are zero, so the shifted tail needs no extra clearing.
    always_comb begin
        base = int'(count_i) - int'(pop_n_i);
        for (int i = 0; i < DEPTH; i++) begin
            buf_o[i] = (i + int'(pop_n_i) < DEPTH) ? buf_i[i + int'(pop_n_i)] : '0;
            if (i >= base && i < base + int'(wr_n_i)) buf_o[i] = lane_get(wr_data_i, i - base);
        end
        count_o = CNT_W'(base + int'(wr_n_i));
    end
endmodule

// File: rtl/byte_pack_fifo.sv
// byte_pack_fifo: packs 0..4-byte writes into a byte stream and pops fixed 4-byte words,
// with flush releasing a zero-padded partial word.
module byte_pack_fifo
    import byte_pack_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    byte_pack_fifo_if.slave bus
);
    logic [DEPTH-1:0][BYTE_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [31:0]                  dout_q, pop_word;
    logic [2:0]                   dout_bytes_q, pop_n, wr_n;
    logic                         dout_valid_q, wr_ready;
    logic [1:0]                   err_q, err_d;

    // Ready ignores a same-cycle pop so a full word always fits.
    always_comb begin
        wr_ready = int'(count_q) <= DEPTH - WORD_BYTES;
        pop_n = !bus.rd_en ? 3'd0 : int'(count_q) >= WORD_BYTES ? 3'd4 : bus.flush ? count_q[2:0] : 3'd0;
        wr_n = (bus.wr_en && wr_ready && bus.wr_bytes <= 3'd4) ? bus.wr_bytes : 3'd0;
        pop_word = '0;
        for (int k = 0; k < WORD_BYTES; k++)
            if (k < int'(pop_n)) pop_word = lane_put(pop_word, k, buf_q[k]);
        err_d = err_q;
        err_d[ERR_DROP]  = err_q[ERR_DROP] | (bus.wr_en && !wr_ready);
        err_d[ERR_BYTES] = err_q[ERR_BYTES] | (bus.wr_en && bus.wr_bytes > 3'd4);
    end

    byte_pack_merge #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_merge (
        .buf_i     (buf_q),
        .count_i   (count_q),
        .pop_n_i   (pop_n),
        .wr_data_i (bus.wr_data),
        .wr_n_i    (wr_n),
        .buf_o     (buf_d),
        .count_o   (count_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q        <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_bytes_q <= '0;
            err_q        <= '0;
        end else begin
            buf_q        <= buf_d;
            count_q      <= count_d;
            err_q        <= err_d;
            dout_valid_q <= pop_n != 3'd0;
            if (pop_n != 3'd0) begin
                dout_q       <= pop_word;
                dout_bytes_q <= pop_n;
            end
        end
    end

    assign bus.wr_ready   = wr_ready;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_bytes = dout_bytes_q;
    assign bus.count      = count_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_byte_pack_fifo.sv
// tb_byte_pack_fifo: directed vectors for the byte packer plus a random run against a byte queue.
module tb_byte_pack_fifo;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    byte_pack_fifo_if #(.DEPTH(16)) bus();
    byte_pack_fifo #(.DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic we, input logic [31:0] d, input logic [2:0] nb,
                        input logic rd, input logic fl);
        bus.wr_en = we; bus.wr_data = d; bus.wr_bytes = nb; bus.rd_en = rd; bus.flush = fl;
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_bytes = '0; bus.rd_en = 1'b0; bus.flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        byte unsigned q[$];
        logic [31:0] exp_word, d;
        int exp_n, sz, nb;
        logic we, rd, fl, exp_err0;
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_bytes = '0; bus.rd_en = 1'b0; bus.flush = 1'b0;
        // 1: reset state and a single full word
        do_reset();
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_bytes", 32'(bus.dout_bytes), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_ready", 32'(bus.wr_ready), 1);
        step(1, 32'hA1B2C3D4, 4, 0, 0);
        chk("t1_count_wr", 32'(bus.count), 4);
        step(0, 0, 0, 1, 0);
        chk("t1_dout", bus.dout, 32'hA1B2C3D4);
        chk("t1_bytes", 32'(bus.dout_bytes), 4);
        chk("t1_valid", 32'(bus.dout_valid), 1);
        chk("t1_count", 32'(bus.count), 0);
        // 2: fragments pack across word boundaries
        step(1, 32'h11DEADBE, 1, 0, 0);
        step(1, 32'h2233BEEF, 2, 0, 0);
        step(1, 32'h445566FF, 3, 0, 0);
        step(1, 32'h77CAFE00, 1, 0, 0);
        chk("t2_count7", 32'(bus.count), 7);
        step(0, 0, 0, 1, 0);
        chk("t2_dout", bus.dout, 32'h11223344);
        chk("t2_count3", 32'(bus.count), 3);
        step(0, 0, 0, 1, 0);
        chk("t2_nopop_valid", 32'(bus.dout_valid), 0);
        chk("t2_nopop_count", 32'(bus.count), 3);
        // 3: partial word needs flush
        step(0, 0, 0, 1, 0);
        chk("t3_held_valid", 32'(bus.dout_valid), 0);
        chk("t3_held_dout", bus.dout, 32'h11223344);
        chk("t3_held_bytes", 32'(bus.dout_bytes), 4);
        step(0, 0, 0, 1, 1);
        chk("t3_flush_dout", bus.dout, 32'h55667700);
        chk("t3_flush_bytes", 32'(bus.dout_bytes), 3);
        chk("t3_flush_valid", 32'(bus.dout_valid), 1);
        chk("t3_flush_count", 32'(bus.count), 0);
        step(0, 0, 0, 1, 1);
        chk("t3_empty_flush_valid", 32'(bus.dout_valid), 0);
        chk("t3_empty_flush_dout", bus.dout, 32'h55667700);
        // 4: full boundary, dropped and illegal writes
        step(1, 32'h01020304, 4, 0, 0);
        step(1, 32'h05060708, 4, 0, 0);
        step(1, 32'h090A0B0C, 4, 0, 0);
        chk("t4_count12", 32'(bus.count), 12);
        chk("t4_ready12", 32'(bus.wr_ready), 1);
        step(1, 32'h0D000000, 1, 0, 0);
        chk("t4_count13", 32'(bus.count), 13);
        chk("t4_ready13", 32'(bus.wr_ready), 0);
        chk("t4_err_clean", 32'(bus.err), 0);
        step(1, 32'hEEEEEEEE, 4, 0, 0);
        chk("t4_drop_count", 32'(bus.count), 13);
        chk("t4_drop_err", 32'(bus.err), 2'b01);
        step(1, 32'hEEEEEEEE, 5, 0, 0);
        chk("t4_bad_err", 32'(bus.err), 2'b11);
        chk("t4_bad_count", 32'(bus.count), 13);
        do_reset();
        chk("t4_rst_err", 32'(bus.err), 0);
        chk("t4_rst_count", 32'(bus.count), 0);
        chk("t4_rst_ready", 32'(bus.wr_ready), 1);
        step(1, 32'h12345678, 5, 0, 0);
        chk("t4_bad_ready_err", 32'(bus.err), 2'b10);
        chk("t4_bad_ready_count", 32'(bus.count), 0);
        do_reset();
        // 5: simultaneous pop and write
        step(1, 32'h01020304, 4, 0, 0);
        step(1, 32'h0506FFFF, 2, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("t5_wr0_count", 32'(bus.count), 6);
        step(1, 32'hAABB0000, 2, 1, 0);
        chk("t5_dout", bus.dout, 32'h01020304);
        chk("t5_count", 32'(bus.count), 4);
        step(0, 0, 0, 1, 0);
        chk("t5_dout2", bus.dout, 32'h0506AABB);
        chk("t5_count2", 32'(bus.count), 0);
        step(1, 32'hC1C2C3FF, 3, 0, 0);
        step(1, 32'hD1000000, 1, 1, 1);
        chk("t5_flush_wr_dout", bus.dout, 32'hC1C2C300);
        chk("t5_flush_wr_bytes", 32'(bus.dout_bytes), 3);
        chk("t5_flush_wr_count", 32'(bus.count), 1);
        // 6: random traffic against a byte queue
        do_reset();
        exp_n = 0;
        exp_word = '0;
        exp_err0 = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            if (exp_n != 0) begin
                chk("rnd_valid", 32'(bus.dout_valid), 1);
                chk("rnd_dout", bus.dout, exp_word);
                chk("rnd_bytes", 32'(bus.dout_bytes), 32'(exp_n));
            end else chk("rnd_idle_valid", 32'(bus.dout_valid), 0);
            chk("rnd_count", 32'(bus.count), 32'(q.size()));
            chk("rnd_count_max", 32'(bus.count <= 16), 1);
            we = 1'($urandom_range(0, 1));
            nb = $urandom_range(0, 4);
            d = $urandom;
            rd = ((cyc / 500) % 2 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) == 0);
            fl = $urandom_range(0, 7) == 0;
            sz = q.size();
            exp_n = (rd && sz >= 4) ? 4 : (rd && fl && sz > 0) ? sz : 0;
            exp_word = '0;
            for (int k = 0; k < exp_n; k++) exp_word[31 - 8*k -: 8] = q.pop_front();
            if (we && sz > 12) exp_err0 = 1'b1;
            if (we && sz <= 12)
                for (int k = 0; k < nb; k++) q.push_back(d[31 - 8*k -: 8]);
            bus.wr_en = we; bus.wr_data = d; bus.wr_bytes = 3'(nb); bus.rd_en = rd; bus.flush = fl;
        end
        @(negedge clk);
        if (exp_n != 0) chk("rnd_last_dout", bus.dout, exp_word);
        chk("rnd_last_count", 32'(bus.count), 32'(q.size()));
        chk("rnd_err", 32'(bus.err), {30'b0, 1'b0, exp_err0});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
